pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised inter-stage pipeline register replacing the fixed IF_ID/ID_EX/EX_MEM/MEM_WB latches.
//   Carries a packed DATA_W payload between adjacent stages with a valid/ready handshake.
//   Adds an optional 2-entry skid buffer, synchronous flush with bubble (NOP) insertion, and a stall counter.
//   One instance sits between each pair of pipeline stages (fetch->decode ... memory->wb).
// PARAMETERS
//   DATA_W   64     payload width in bits (packed control + data fields of the stage)
//   NOP_VAL  '0     payload driven on out_data when out_valid=0 and loaded on flush (bubble)
//   SKID_EN  1      1: 2-entry skid buffer with registered in_ready; 0: single entry with combinational in_ready
//   CNT_W    16     width of the stall_cycles counter
// PORTS
//   clk           in   1        clock, all state updates on the rising edge
//   rst           in   1        asynchronous, active-low reset
//   in_valid      in   1        upstream stage presents a valid payload
//   in_ready      out  1        this register accepts the payload this cycle
//   in_data       in   DATA_W   upstream payload
//   flush         in   1        synchronous kill: discard all held entries (branch taken / halt)
//   out_valid     out  1        held payload valid for the downstream stage
//   out_ready     in   1        downstream stage consumes out_data this cycle
//   out_data      out  DATA_W   payload to the downstream stage; NOP_VAL when out_valid=0
//   occupancy     out  2        number of held entries (0..2; max 1 when SKID_EN=0)
//   stall_cycles  out  CNT_W    saturating count of cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//   in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//   Reset (rst=0, async): state EMPTY; main/skid regs = NOP_VAL; out_valid=0; out_data=NOP_VAL;
//     in_ready=0; occupancy=0; stall_cycles=0. First edge after release: in_ready=1.
//   States (SKID_EN=1): EMPTY (occ 0), ONE (occ 1, payload in main), TWO (occ 2, main + skid).
//     EMPTY: in_fire -> ONE, main<=in_data.
//     ONE:   in_fire & out_fire -> ONE, main<=in_data; in_fire & !out_fire -> TWO, skid<=in_data;
//            !in_fire & out_fire -> EMPTY, main<=NOP_VAL; otherwise hold.
//     TWO:   out_fire -> ONE, main<=skid, skid<=NOP_VAL; otherwise hold. in_fire impossible.
//   in_ready (SKID_EN=1): registered, =1 iff next state != TWO; never depends on out_ready combinationally.
//   SKID_EN=0: states EMPTY/ONE only; in_ready = !out_valid | out_ready (combinational); TWO unreachable.
//   out_valid = (state != EMPTY); out_data = main reg (equals NOP_VAL whenever EMPTY).
//   Latency: 1 cycle from in_fire (EMPTY) to out_valid; throughput 1 payload/cycle with out_ready=1.
//   Ordering: strict FIFO; payloads never duplicated or reordered; main always holds the oldest.
//   flush (highest priority, synchronous): next state EMPTY; main/skid<=NOP_VAL; an in_fire in the
//     same cycle is discarded; an out_fire in the same cycle is a valid consumption by downstream.
//     in_ready after a flush edge = 1 (rst released).
//   stall_cycles: +1 on each edge where out_valid & !out_ready; saturates at all-ones; unaffected by
//     flush; cleared only by reset.
//   Reset asserted mid-transfer: all entries dropped immediately, outputs take reset values asynchronously.
//   X-safety: in_data is sampled only on in_fire; out_data never shows X after reset.
// TESTING
//   1 Reset: rst=0 with in_valid=1 -> out_valid=0, out_data=NOP_VAL, in_ready=0, occupancy=0, stall_cycles=0.
//   2 Streaming: out_ready=1, in_valid=1, data 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3
//     one cycle later each, occupancy stays 1, in_ready stays 1.
//   3 Skid fill: push 0xA then 0xB with out_ready=0 -> occupancy 2, in_ready=0, out_data=0xA,
//     stall_cycles counts up 1/cycle; raise out_ready -> 0xA then 0xB emitted, occupancy 2->1->0.
//   4 Flush while full: occupancy 2, flush=1 with in_valid=1 data 0xC -> next cycle out_valid=0,
//     out_data=NOP_VAL, occupancy 0, 0xC never appears at the output.
//   5 SKID_EN=0: out_ready=0 with one entry held -> in_ready=0 same cycle; out_ready=1 -> in_ready=1
//     same cycle, simultaneous in/out transfers keep occupancy 1.
//   6 Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles -> stall_cycles=4'hF, no wrap.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with valid/ready handshake,
// optional 2-entry skid buffer, flush-to-bubble and saturating stall counter.
module pipe_stage_reg #(
  parameter int                DATA_W  = 64,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID_EN = 1'b1,
  parameter int                CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              rdy_q, rdy_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              in_fire, out_fire;

  assign out_valid    = (state_q != ST_EMPTY);
  assign out_data     = main_q;
  assign occupancy    = state_q;
  assign stall_cycles = stall_q;
  assign in_fire      = in_valid & in_ready;
  assign out_fire     = out_valid & out_ready;

  // rdy_q also gates the single-entry variant so in_ready stays low until the first edge after reset
  if (SKID_EN) begin : g_skid
    assign in_ready = rdy_q;
  end else begin : g_noskid
    assign in_ready = rdy_q & (~out_valid | out_ready);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && SKID_EN) begin
            state_d = ST_TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_VAL;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_comb begin
    rdy_d   = (state_d != ST_TWO);
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
      rdy_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - bench for pipe_stage_reg: skid instance (CNT_W=4) and
// single-entry instance share stimulus; a queue model is compared every cycle.
module tb_pipe_stage_reg;

  localparam int          DW  = 16;
  localparam logic [15:0] NOP = 16'hBEEF;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          a_in_ready, a_out_valid;
  logic [DW-1:0] a_out_data;
  logic [1:0]    a_occ;
  logic [3:0]    a_stall;
  logic          b_in_ready, b_out_valid;
  logic [DW-1:0] b_out_data;
  logic [1:0]    b_occ;
  logic [15:0]   b_stall;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(DW), .NOP_VAL(NOP), .SKID_EN(1'b1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cycles(a_stall)
  );

  pipe_stage_reg #(.DATA_W(DW), .NOP_VAL(NOP), .SKID_EN(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cycles(b_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each instance is a bounded FIFO (capacity 2 / 1)
  logic [DW-1:0] qa[$];
  logic [DW-1:0] qb[$];
  bit rdy_a = 1'b0;
  bit st_b  = 1'b0;
  int sa = 0;
  int sb = 0;

  function automatic bit b_rdy();
    return st_b && (qb.size() == 0 || out_ready);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      qa.delete(); qb.delete();
      rdy_a = 1'b0; st_b = 1'b0; sa = 0; sb = 0;
    end else begin
      bit fa_in, fa_out, fb_in, fb_out;
      fa_in  = in_valid && rdy_a;
      fa_out = (qa.size() > 0) && out_ready;
      fb_in  = in_valid && b_rdy();
      fb_out = (qb.size() > 0) && out_ready;
      if (qa.size() > 0 && !out_ready && sa < 15)    sa++;
      if (qb.size() > 0 && !out_ready && sb < 65535) sb++;
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (fa_out) void'(qa.pop_front());
        if (fa_in)  qa.push_back(in_data);
        if (fb_out) void'(qb.pop_front());
        if (fb_in)  qb.push_back(in_data);
      end
      rdy_a = (qa.size() < 2);
      st_b  = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("mon a_out_valid", {31'd0, a_out_valid}, {31'd0, qa.size() > 0});
    chk("mon a_out_data", {16'd0, a_out_data}, {16'd0, (qa.size() > 0) ? qa[0] : NOP});
    chk("mon a_occ", {30'd0, a_occ}, qa.size());
    chk("mon a_in_ready", {31'd0, a_in_ready}, {31'd0, rdy_a});
    chk("mon a_stall", {28'd0, a_stall}, sa);
    chk("mon b_out_valid", {31'd0, b_out_valid}, {31'd0, qb.size() > 0});
    chk("mon b_out_data", {16'd0, b_out_data}, {16'd0, (qb.size() > 0) ? qb[0] : NOP});
    chk("mon b_occ", {30'd0, b_occ}, qb.size());
    chk("mon b_in_ready", {31'd0, b_in_ready}, {31'd0, b_rdy()});
    chk("mon b_stall", {16'd0, b_stall}, sb);
  end

  task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_data = 16'h0055; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst a_out_data", {16'd0, a_out_data}, 32'h0000BEEF);
    chk("rst a_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("rst a_occ", {30'd0, a_occ}, 32'd0);
    chk("rst a_stall", {28'd0, a_stall}, 32'd0);
    chk("rst b_in_ready", {31'd0, b_in_ready}, 32'd0);
    rst = 1'b1;
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("post-rst a_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("post-rst b_in_ready", {31'd0, b_in_ready}, 32'd1);

    cyc(1'b1, 16'h0001, 1'b1, 1'b0);
    chk("stream a_data1", {16'd0, a_out_data}, 32'h1);
    chk("stream a_occ1", {30'd0, a_occ}, 32'd1);
    cyc(1'b1, 16'h0002, 1'b1, 1'b0);
    chk("stream a_data2", {16'd0, a_out_data}, 32'h2);
    chk("stream b_data2", {16'd0, b_out_data}, 32'h2);
    cyc(1'b1, 16'h0003, 1'b1, 1'b0);
    chk("stream a_data3", {16'd0, a_out_data}, 32'h3);
    chk("stream a_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("stream b_occ", {30'd0, b_occ}, 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("drain a_out_valid", {31'd0, a_out_valid}, 32'd0);

    cyc(1'b1, 16'h000A, 1'b0, 1'b0);
    chk("skid a_occ1", {30'd0, a_occ}, 32'd1);
    cyc(1'b1, 16'h000B, 1'b0, 1'b0);
    chk("skid a_occ2", {30'd0, a_occ}, 32'd2);
    chk("skid a_in_ready", {31'd0, a_in_ready}, 32'd0);
    chk("skid a_data", {16'd0, a_out_data}, 32'hA);
    chk("skid a_stall1", {28'd0, a_stall}, 32'd1);
    cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("skid a_stall2", {28'd0, a_stall}, 32'd2);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("skid a_dataB", {16'd0, a_out_data}, 32'hB);
    chk("skid a_occ->1", {30'd0, a_occ}, 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("skid a_occ->0", {30'd0, a_occ}, 32'd0);
    chk("skid a_nop", {16'd0, a_out_data}, 32'h0000BEEF);

    cyc(1'b1, 16'h0011, 1'b0, 1'b0);
    cyc(1'b1, 16'h0012, 1'b0, 1'b0);
    chk("flush pre a_occ", {30'd0, a_occ}, 32'd2);
    cyc(1'b1, 16'h000C, 1'b0, 1'b1);
    chk("flush a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush a_nop", {16'd0, a_out_data}, 32'h0000BEEF);
    chk("flush a_occ", {30'd0, a_occ}, 32'd0);
    chk("flush a_in_ready", {31'd0, a_in_ready}, 32'd1);
    chk("flush a_stall", {28'd0, a_stall}, 32'd4);
    chk("flush b_occ", {30'd0, b_occ}, 32'd0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    chk("flush no 0xC", {31'd0, a_out_valid}, 32'd0);

    cyc(1'b1, 16'h0021, 1'b0, 1'b0);
    chk("noskid held rdy0", {31'd0, b_in_ready}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("noskid comb rdy1", {31'd0, b_in_ready}, 32'd1);
    cyc(1'b1, 16'h0022, 1'b1, 1'b0);
    chk("noskid b_data22", {16'd0, b_out_data}, 32'h22);
    chk("noskid b_occ", {30'd0, b_occ}, 32'd1);
    chk("noskid a_data22", {16'd0, a_out_data}, 32'h22);
    cyc(1'b1, 16'h0023, 1'b1, 1'b0);
    chk("noskid b_data23", {16'd0, b_out_data}, 32'h23);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);

    cyc(1'b1, 16'h0031, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, 16'h0, 1'b0, 1'b0);
    chk("sat a_stall", {28'd0, a_stall}, 32'hF);
    chk("sat a_data", {16'd0, a_out_data}, 32'h31);
    chk("sat b_stall", {16'd0, b_stall}, 32'd24);

    #2;
    rst = 1'b0;
    #1;
    chk("async a_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("async a_nop", {16'd0, a_out_data}, 32'h0000BEEF);
    chk("async a_occ", {30'd0, a_occ}, 32'd0);
    chk("async a_stall", {28'd0, a_stall}, 32'd0);
    chk("async b_out_valid", {31'd0, b_out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc(1'b0, 16'h0, 1'b1, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
